kbd_key_tracker: RTL and testbench

Parametrised keyboard key tracker. It consumes decoded PS/2 scan events (`key_Pressed`, `make`, `brakee`) and tracks the held state of NUM_KEYS configurable keys. For each key it generates one-cycle press, release and auto-repeat pulses. It sits between the keyboard scan-code receiver and game control logic (player movement, menu navigation), and replaces fixed four-direction decoding with a configurable key set and typematic timing.

---
 rtl/kbd_key_tracker.sv | 165 ++++++++++++++++
 tb/tb_kbd_key_tracker.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_key_tracker.sv
// kbd_key_tracker
//   Tracks the held state of NUM_KEYS configurable keys from decoded PS/2
//   scan events. For each key it produces one-cycle press, release and
//   auto-repeat (typematic) pulses for game/menu control logic.
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous, active-high reset
//   key_pressed_i  scan code of the current event (bit 8 = extended flag)
//   make_i         one-cycle strobe: key_pressed_i was pressed
//   brakee_i       one-cycle strobe: key_pressed_i was released
//   held_o         per-key level, high from press until release
//   press_o        per-key one-cycle press pulse
//   release_o      per-key one-cycle release pulse
//   repeat_o       per-key one-cycle auto-repeat pulse
//   fire_o         press_o | repeat_o
//   last_key_o     index of the most recently pressed tracked key
//   any_held_o     OR of held_o
//
// Channel FSM
//   state      | meaning
//   ST_IDLE    | key not held
//   ST_DELAY   | key held, waiting REPEAT_DELAY cycles for first repeat
//   ST_REPEAT  | key held, repeating every REPEAT_PERIOD cycles
module kbd_key_tracker #(
  parameter int                    NUM_KEYS      = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES     = {9'h023, 9'h01C, 9'h01B, 9'h01D},
  parameter bit                    REPEAT_EN     = 1'b1,
  parameter int                    REPEAT_DELAY  = 25_000_000,
  parameter int                    REPEAT_PERIOD = 5_000_000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [8:0]          key_pressed_i,
  input  logic                make_i,
  input  logic                brakee_i,
  output logic [NUM_KEYS-1:0] held_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic [NUM_KEYS-1:0] release_o,
  output logic [NUM_KEYS-1:0] repeat_o,
  output logic [NUM_KEYS-1:0] fire_o,
  output logic [3:0]          last_key_o,
  output logic                any_held_o
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DELAY_TC  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_TC = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [NUM_KEYS-1:0] press_d,   press_q;
  logic [NUM_KEYS-1:0] release_d, release_q;
  logic [NUM_KEYS-1:0] repeat_d,  repeat_q;
  logic [NUM_KEYS-1:0] held_w;
  logic [3:0]          last_key_d, last_key_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit;
    logic          press_n, release_n, repeat_n;

    assign hit = (key_pressed_i == KEY_CODES[i*9 +: 9]);

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_n   = 1'b0;
      release_n = 1'b0;
      repeat_n  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          // brakee has priority, so a simultaneous make is dropped
          if (hit && make_i && !brakee_i) begin
            state_d = ST_DELAY;
            cnt_d   = '0;
            press_n = 1'b1;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          // Release wins over a repeat falling due in the same cycle;
          // a resent make while held leaves state and phase untouched.
          if (hit && brakee_i) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            release_n = 1'b1;
          end else if (state_q == ST_DELAY) begin
            if (REPEAT_EN) begin
              if (cnt_q == DELAY_TC) begin
                state_d  = ST_REPEAT;
                cnt_d    = '0;
                repeat_n = 1'b1;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end else begin
            if (cnt_q == PERIOD_TC) begin
              cnt_d    = '0;
              repeat_n = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign press_d[i]   = press_n;
    assign release_d[i] = release_n;
    assign repeat_d[i]  = repeat_n;
    assign held_w[i]    = (state_q != ST_IDLE);
  end

  // Highest-index channel wins if several are pressed in the same cycle.
  always_comb begin
    last_key_d = last_key_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (press_d[k]) last_key_d = 4'(k);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      press_q    <= '0;
      release_q  <= '0;
      repeat_q   <= '0;
      last_key_q <= '0;
    end else begin
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
      last_key_q <= last_key_d;
    end
  end

  assign held_o     = held_w;
  assign press_o    = press_q;
  assign release_o  = release_q;
  assign repeat_o   = repeat_q;
  assign fire_o     = press_q | repeat_q;
  assign last_key_o = last_key_q;
  assign any_held_o = |held_w;

endmodule

// File: tb/tb_kbd_key_tracker.sv
// tb_kbd_key_tracker
//   Directed bench for kbd_key_tracker. dut uses REPEAT_DELAY=4,
//   REPEAT_PERIOD=2 with repeat enabled; dut2 is identical but with
//   repeat disabled. Both share clock, reset and event inputs.
//   Channel map (default codes): ch0=9'h01D, ch1=9'h01B, ch2=9'h01C, ch3=9'h023.
module tb_kbd_key_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] key = '0;
  logic       make = 1'b0;
  logic       brakee = 1'b0;

  logic [3:0] held, press, rel, rpt, fire, last_key;
  logic       any_held;
  logic [3:0] held2, press2, rel2, rpt2, fire2, last_key2;
  logic       any_held2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kbd_key_tracker #(
    .NUM_KEYS(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .key_pressed_i(key), .make_i(make), .brakee_i(brakee),
    .held_o(held), .press_o(press), .release_o(rel), .repeat_o(rpt), .fire_o(fire),
    .last_key_o(last_key), .any_held_o(any_held)
  );

  kbd_key_tracker #(
    .NUM_KEYS(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .key_pressed_i(key), .make_i(make), .brakee_i(brakee),
    .held_o(held2), .press_o(press2), .release_o(rel2), .repeat_o(rpt2), .fire_o(fire2),
    .last_key_o(last_key2), .any_held_o(any_held2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({held, press, rel, rpt, fire, last_key, any_held} !== '0 ||
        {held2, press2, rel2, rpt2, fire2, last_key2, any_held2} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: held=%b press=%b rel=%b rpt=%b last=%0d any=%b, required all 0",
               held, press, rel, rpt, last_key, any_held);
    end
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if ({held, press, rel, rpt, fire, last_key, any_held} !== '0 ||
          {held2, press2, rel2, rpt2, fire2, last_key2, any_held2} !== '0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_idle: %0d cycles with nonzero outputs, required 0", bad);
    end
  endtask

  task automatic test_press_release();
    logic [3:0] exp_rpt;
    key = 9'h01D; make = 1'b1;
    tick();                                  // cycle 11
    make = 1'b0;
    n_checks++;
    if (press !== 4'b0001 || held !== 4'b0001 || rpt !== 4'b0000 || fire !== 4'b0001 ||
        last_key !== 4'd0 || any_held !== 1'b1) begin
      n_fail++;
      $display("FAIL pr_press: press=%b held=%b rpt=%b fire=%b last=%0d any=%b, required 0001 0001 0000 0001 0 1",
               press, held, rpt, fire, last_key, any_held);
    end
    for (int c = 12; c <= 20; c++) begin
      tick();
      exp_rpt = (c == 15 || c == 17 || c == 19) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (press !== 4'b0000 || held !== 4'b0001 || rpt !== exp_rpt || fire !== exp_rpt ||
          rel !== 4'b0000 || any_held !== 1'b1) begin
        n_fail++;
        $display("FAIL pr_hold_c%0d: press=%b held=%b rpt=%b fire=%b rel=%b, required 0000 0001 %b %b 0000",
                 c, press, held, rpt, fire, rel, exp_rpt, exp_rpt);
      end
    end
    brakee = 1'b1;
    tick();                                  // cycle 21
    brakee = 1'b0;
    n_checks++;
    if (rel !== 4'b0001 || held !== 4'b0000 || rpt !== 4'b0000 || any_held !== 1'b0 ||
        last_key !== 4'd0) begin
      n_fail++;
      $display("FAIL pr_release: rel=%b held=%b rpt=%b any=%b last=%0d, required 0001 0000 0000 0 0",
               rel, held, rpt, any_held, last_key);
    end
    tick();
    n_checks++;
    if (rel !== 4'b0000 || rpt !== 4'b0000) begin
      n_fail++;
      $display("FAIL pr_release_len: rel=%b rpt=%b, required 0000 0000", rel, rpt);
    end
  endtask

  task automatic test_ignored();
    key = 9'h029; make = 1'b1;
    tick();
    make = 1'b0;
    n_checks++;
    if (held !== 4'b0000 || press !== 4'b0000 || rpt !== 4'b0000 || rel !== 4'b0000 ||
        last_key !== 4'd0 || any_held !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_unmapped: held=%b press=%b rpt=%b rel=%b last=%0d, required 0 0 0 0 0",
               held, press, rpt, rel, last_key);
    end
    key = 9'h01C; brakee = 1'b1;
    tick();
    brakee = 1'b0;
    n_checks++;
    if (rel !== 4'b0000 || held !== 4'b0000) begin
      n_fail++;
      $display("FAIL ign_brk_idle: rel=%b held=%b, required 0000 0000", rel, held);
    end
    // duplicate make one cycle after press must not restart the delay
    key = 9'h01D; make = 1'b1;
    tick();                                  // p
    make = 1'b0;
    tick();                                  // p+1
    make = 1'b1;
    tick();                                  // p+2
    make = 1'b0;
    n_checks++;
    if (press !== 4'b0000 || held !== 4'b0001) begin
      n_fail++;
      $display("FAIL ign_dup_press: press=%b held=%b, required 0000 0001", press, held);
    end
    tick();                                  // p+3
    n_checks++;
    if (rpt !== 4'b0000) begin
      n_fail++;
      $display("FAIL ign_dup_p3: rpt=%b, required 0000", rpt);
    end
    tick();                                  // p+4
    n_checks++;
    if (rpt !== 4'b0001) begin
      n_fail++;
      $display("FAIL ign_dup_p4: rpt=%b, required 0001", rpt);
    end
    tick();                                  // p+5
    tick();                                  // p+6
    n_checks++;
    if (rpt !== 4'b0001) begin
      n_fail++;
      $display("FAIL ign_dup_p6: rpt=%b, required 0001", rpt);
    end
    brakee = 1'b1;
    tick();
    brakee = 1'b0;
    n_checks++;
    if (rel !== 4'b0001 || held !== 4'b0000) begin
      n_fail++;
      $display("FAIL ign_dup_rel: rel=%b held=%b, required 0001 0000", rel, held);
    end
  endtask

  task automatic test_simultaneous();
    key = 9'h023; make = 1'b1; brakee = 1'b1;
    tick();
    make = 1'b0; brakee = 1'b0;
    n_checks++;
    if (held !== 4'b0000 || press !== 4'b0000 || rel !== 4'b0000) begin
      n_fail++;
      $display("FAIL sim_idle: held=%b press=%b rel=%b, required 0000 0000 0000", held, press, rel);
    end
    make = 1'b1;
    tick();
    make = 1'b0;
    n_checks++;
    if (held !== 4'b1000 || press !== 4'b1000 || last_key !== 4'd3) begin
      n_fail++;
      $display("FAIL sim_press_d: held=%b press=%b last=%0d, required 1000 1000 3", held, press, last_key);
    end
    make = 1'b1; brakee = 1'b1;
    tick();
    make = 1'b0; brakee = 1'b0;
    n_checks++;
    if (rel !== 4'b1000 || held !== 4'b0000 || press !== 4'b0000) begin
      n_fail++;
      $display("FAIL sim_held: rel=%b held=%b press=%b, required 1000 0000 0000", rel, held, press);
    end
  endtask

  task automatic test_multi_key();
    key = 9'h01D; make = 1'b1;
    tick();                                  // a
    make = 1'b0;
    n_checks++;
    if (held !== 4'b0001 || press !== 4'b0001 || last_key !== 4'd0) begin
      n_fail++;
      $display("FAIL mk_press_w: held=%b press=%b last=%0d, required 0001 0001 0", held, press, last_key);
    end
    tick();                                  // a+1
    key = 9'h023; make = 1'b1;
    tick();                                  // a+2
    make = 1'b0;
    n_checks++;
    if (held !== 4'b1001 || press !== 4'b1000 || last_key !== 4'd3 || any_held !== 1'b1) begin
      n_fail++;
      $display("FAIL mk_press_d: held=%b press=%b last=%0d any=%b, required 1001 1000 3 1",
               held, press, last_key, any_held);
    end
    tick();                                  // a+3
    tick();                                  // a+4
    n_checks++;
    if (rpt !== 4'b0001 || fire !== 4'b0001) begin
      n_fail++;
      $display("FAIL mk_rpt_a4: rpt=%b fire=%b, required 0001 0001", rpt, fire);
    end
    tick();                                  // a+5
    n_checks++;
    if (rpt !== 4'b0000) begin
      n_fail++;
      $display("FAIL mk_rpt_a5: rpt=%b, required 0000", rpt);
    end
    tick();                                  // a+6
    n_checks++;
    if (rpt !== 4'b1001 || fire !== 4'b1001) begin
      n_fail++;
      $display("FAIL mk_rpt_a6: rpt=%b fire=%b, required 1001 1001", rpt, fire);
    end
    key = 9'h01D; brakee = 1'b1;
    tick();                                  // a+7
    brakee = 1'b0;
    n_checks++;
    if (held !== 4'b1000 || rel !== 4'b0001 || any_held !== 1'b1 || last_key !== 4'd3) begin
      n_fail++;
      $display("FAIL mk_rel_w: held=%b rel=%b any=%b last=%0d, required 1000 0001 1 3",
               held, rel, any_held, last_key);
    end
    tick();                                  // a+8
    n_checks++;
    if (rpt !== 4'b1000 || held !== 4'b1000) begin
      n_fail++;
      $display("FAIL mk_rpt_a8: rpt=%b held=%b, required 1000 1000", rpt, held);
    end
    key = 9'h023; brakee = 1'b1;
    tick();
    brakee = 1'b0;
    n_checks++;
    if (held !== 4'b0000 || rel !== 4'b1000 || any_held !== 1'b0) begin
      n_fail++;
      $display("FAIL mk_rel_d: held=%b rel=%b any=%b, required 0000 1000 0", held, rel, any_held);
    end
  endtask

  task automatic test_repeat_disabled_reset();
    int bad;
    key = 9'h01B; make = 1'b1;
    tick();
    make = 1'b0;
    n_checks++;
    if (held2 !== 4'b0010 || press2 !== 4'b0010 || fire2 !== 4'b0010 || last_key2 !== 4'd1) begin
      n_fail++;
      $display("FAIL nr_press: held=%b press=%b fire=%b last=%0d, required 0010 0010 0010 1",
               held2, press2, fire2, last_key2);
    end
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (rpt2 !== 4'b0000 || fire2 !== 4'b0000 || held2 !== 4'b0010) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL nr_no_repeat: %0d bad cycles (repeat/fire nonzero or not held), required 0", bad);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (held2 !== 4'b0000 || any_held2 !== 1'b0 || rel2 !== 4'b0000 || held !== 4'b0000) begin
      n_fail++;
      $display("FAIL nr_async_rst: held2=%b any2=%b rel2=%b held=%b, required 0000 0 0000 0000",
               held2, any_held2, rel2, held);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (rel2 !== 4'b0000 || held2 !== 4'b0000 || rel !== 4'b0000 || last_key2 !== 4'd0) begin
      n_fail++;
      $display("FAIL nr_post_rst: rel2=%b held2=%b rel=%b last2=%0d, required 0000 0000 0000 0",
               rel2, held2, rel, last_key2);
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_ignored();
    test_simultaneous();
    test_multi_key();
    test_repeat_disabled_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
